// File: rtl/reg_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_cmd_master : ASCII register-access command initiator over UDP   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module reg_cmd_master #(
  parameter int REGS_NUM       = 4,
  parameter int REG_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                                                i_clk,
  input  logic                                                i_rst_n,
  input  logic                                                i_cmd_valid,
  output logic                                                o_cmd_ready,
  input  logic                                                i_cmd_write,
  input  logic [((REGS_NUM > 1) ? $clog2(REGS_NUM) : 1)-1:0] i_cmd_reg,
  input  logic [REG_WIDTH-1:0]                                i_cmd_wdata,
  output logic [7:0]                                          o_tx_udp_payload_axis_tdata,
  output logic                                                o_tx_udp_payload_axis_tvalid,
  output logic                                                o_tx_udp_payload_axis_tlast,
  input  logic                                                i_tx_udp_payload_axis_tready,
  input  logic [7:0]                                          i_rx_udp_payload_axis_tdata,
  input  logic                                                i_rx_udp_payload_axis_tvalid,
  input  logic                                                i_rx_udp_payload_axis_tlast,
  output logic                                                o_rx_udp_payload_axis_tready,
  output logic                                                o_rsp_valid,
  output logic [REG_WIDTH-1:0]                                o_rsp_rdata,
  output logic                                                o_rsp_error,
  output logic                                                o_busy
);

  localparam int NB        = REG_WIDTH / 8;
  localparam int REG_IDX_W = (REGS_NUM > 1) ? $clog2(REGS_NUM) : 1;
  localparam int CNT_W     = $clog2(NB + 1);
  localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_COLON, S_TX_REG, S_TX_CMD, S_TX_DATA, S_RX_DATA, S_DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic                   write_q, write_d;
  logic [REG_IDX_W-1:0]   reg_q, reg_d;
  logic [REG_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [REG_WIDTH-1:0]   shift_q, shift_d;
  logic [REG_WIDTH-1:0]   rdata_q, rdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_error_q, rsp_error_d;
  logic                   init_q, init_d;
  logic [REG_WIDTH-1:0]   w_rx_word;

  // init_q keeps o_cmd_ready low for the single cycle that follows reset
  assign o_cmd_ready  = (state_q == S_IDLE) && init_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_rx_udp_payload_axis_tready =
      (state_q == S_IDLE) || (state_q == S_RX_DATA) || (state_q == S_DRAIN);
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_error  = rsp_error_q;
  assign o_rsp_rdata  = rdata_q;
  assign w_rx_word    = (shift_q << 8) | REG_WIDTH'(i_rx_udp_payload_axis_tdata);

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    shift_d     = shift_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    init_d      = 1'b1;
    o_tx_udp_payload_axis_tdata  = 8'h00;
    o_tx_udp_payload_axis_tvalid = 1'b0;
    o_tx_udp_payload_axis_tlast  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          write_d = i_cmd_write;
          reg_d   = i_cmd_reg;
          wdata_d = i_cmd_wdata;
          state_d = S_TX_COLON;
        end
      end
      S_TX_COLON: begin
        o_tx_udp_payload_axis_tvalid = 1'b1;
        o_tx_udp_payload_axis_tdata  = 8'h3A;
        if (i_tx_udp_payload_axis_tready) state_d = S_TX_REG;
      end
      S_TX_REG: begin
        o_tx_udp_payload_axis_tvalid = 1'b1;
        o_tx_udp_payload_axis_tdata  = 8'h30 + 8'(reg_q);
        if (i_tx_udp_payload_axis_tready) state_d = S_TX_CMD;
      end
      S_TX_CMD: begin
        o_tx_udp_payload_axis_tvalid = 1'b1;
        o_tx_udp_payload_axis_tdata  = write_q ? 8'h77 : 8'h72;
        o_tx_udp_payload_axis_tlast  = !write_q;
        if (i_tx_udp_payload_axis_tready) begin
          cnt_d   = '0;
          tmo_d   = '0;
          shift_d = '0;
          state_d = write_q ? S_TX_DATA : S_RX_DATA;
        end
      end
      S_TX_DATA: begin
        o_tx_udp_payload_axis_tvalid = 1'b1;
        o_tx_udp_payload_axis_tdata  = wdata_q[REG_WIDTH-1 -: 8];
        o_tx_udp_payload_axis_tlast  = (cnt_q == LAST_BEAT);
        if (i_tx_udp_payload_axis_tready) begin
          wdata_d = wdata_q << 8;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            rsp_valid_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      S_RX_DATA: begin
        if (i_rx_udp_payload_axis_tvalid) begin
          tmo_d   = '0;
          shift_d = w_rx_word;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            if (i_rx_udp_payload_axis_tlast) begin
              rdata_d     = w_rx_word;
              rsp_valid_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              state_d = S_DRAIN;
            end
          end else if (i_rx_udp_payload_axis_tlast) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DRAIN: begin
        // an over-long response is swallowed whole so the next read starts clean
        if (i_rx_udp_payload_axis_tvalid) begin
          tmo_d = '0;
          if (i_rx_udp_payload_axis_tlast) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      reg_q       <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      shift_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      init_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      shift_q     <= shift_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      init_q      <= init_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_reg_cmd_master : directed self-checking bench for reg_cmd_master |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_reg_cmd_master;

  localparam int REGS_NUM       = 4;
  localparam int REG_WIDTH      = 32;
  localparam int TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_reg;
  logic [31:0] cmd_wdata;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid, tx_tlast, tx_tready;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid, rx_tlast, rx_tready;
  logic        rsp_valid, rsp_error, busy;
  logic [31:0] rsp_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] cap_data[$];
  logic       cap_last[$];
  int         cap_when[$];
  int         cap_hold_err;

  always #5 clk = ~clk;

  reg_cmd_master #(
    .REGS_NUM(REGS_NUM), .REG_WIDTH(REG_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_reg(cmd_reg), .i_cmd_wdata(cmd_wdata),
    .o_tx_udp_payload_axis_tdata(tx_tdata), .o_tx_udp_payload_axis_tvalid(tx_tvalid),
    .o_tx_udp_payload_axis_tlast(tx_tlast), .i_tx_udp_payload_axis_tready(tx_tready),
    .i_rx_udp_payload_axis_tdata(rx_tdata), .i_rx_udp_payload_axis_tvalid(rx_tvalid),
    .i_rx_udp_payload_axis_tlast(rx_tlast), .o_rx_udp_payload_axis_tready(rx_tready),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_error(rsp_error),
    .o_busy(busy)
  );

  // All drivers start and end at a falling edge; the DUT samples on the rising edge.
  task automatic send_cmd(input bit wr, input logic [1:0] rg, input logic [31:0] wd);
    int b;
    b = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_reg = rg; cmd_wdata = wd;
    while (cmd_ready !== 1'b1 && b < 50) begin
      @(negedge clk); b++;
    end
    if (b == 50) begin
      n_vec++; n_err++;
      $display("FAIL cmd_accept_bound: cmd_ready never rose within %0d cycles", b);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Captures one TX frame; k counts cycles since the command was accepted.
  task automatic capture_tx(input bit toggle);
    int k;
    bit done, stalled;
    logic [7:0] st_data;
    logic st_last;
    cap_data.delete(); cap_last.delete(); cap_when.delete();
    cap_hold_err = 0; k = 0; done = 0; stalled = 0; st_data = 8'h00; st_last = 1'b0;
    while (!done && k < 64) begin
      tx_tready = toggle ? k[0] : 1'b1;
      if (stalled && (tx_tvalid !== 1'b1 || tx_tdata !== st_data || tx_tlast !== st_last))
        cap_hold_err++;
      stalled = 0;
      if (tx_tvalid === 1'b1) begin
        if (tx_tready) begin
          cap_data.push_back(tx_tdata); cap_last.push_back(tx_tlast); cap_when.push_back(k);
          if (tx_tlast === 1'b1) done = 1;
        end else begin
          stalled = 1; st_data = tx_tdata; st_last = tx_tlast;
        end
      end
      @(negedge clk); k++;
    end
    tx_tready = 1'b1;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL tx_frame_bound: no tlast after %0d cycles, %0d bytes seen", k, cap_data.size());
    end
  endtask

  task automatic send_rx_byte(input logic [7:0] d, input bit last);
    int b;
    b = 0;
    rx_tvalid = 1'b1; rx_tdata = d; rx_tlast = last;
    while (rx_tready !== 1'b1 && b < 50) begin
      @(negedge clk); b++;
    end
    if (b == 50) begin
      n_vec++; n_err++;
      $display("FAIL rx_accept_bound: rx tready low for %0d cycles", b);
    end
    @(negedge clk);
    rx_tvalid = 1'b0; rx_tlast = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (tx_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b want 0", tx_tvalid); end
    n_vec++; if (tx_tdata !== 8'h00) begin n_err++; $display("FAIL rst_tdata: got %h want 00", tx_tdata); end
    n_vec++; if (tx_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b want 0", tx_tlast); end
    n_vec++; if (rx_tready !== 1'b1) begin n_err++; $display("FAIL rst_rx_tready: got %b want 1", rx_tready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_vec++; if (rsp_error !== 1'b0) begin n_err++; $display("FAIL rst_rsp_error: got %b want 0", rsp_error); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write();
    logic [7:0] exp[7];
    exp = '{8'h3A, 8'h32, 8'h77, 8'hAB, 8'hCD, 8'h12, 8'h34};
    send_cmd(1'b1, 2'd2, 32'hABCD1234);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b want 1", busy); end
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL wr_cmd_ready: got %b want 0", cmd_ready); end
    n_vec++; if (rx_tready !== 1'b0) begin n_err++; $display("FAIL wr_rx_tready: got %b want 0", rx_tready); end
    capture_tx(1'b0);
    n_vec++; if (cap_data.size() != 7) begin n_err++; $display("FAIL wr_len: got %0d want 7", cap_data.size()); end
    for (int i = 0; i < 7 && i < cap_data.size(); i++) begin
      n_vec++;
      if (cap_data[i] !== exp[i] || cap_last[i] !== (i == 6) || cap_when[i] != i) begin
        n_err++;
        $display("FAIL wr_byte%0d: got %h last %b cyc %0d want %h last %b cyc %0d",
                 i, cap_data[i], cap_last[i], cap_when[i], exp[i], (i == 6), i);
      end
    end
    n_vec++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0) begin
      n_err++; $display("FAIL wr_rsp_7cyc: got valid %b err %b want 1 0", rsp_valid, rsp_error);
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_done_busy: got %b want 0", busy); end
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid); end
  endtask

  task automatic test_read();
    send_cmd(1'b0, 2'd2, 32'h0);
    capture_tx(1'b0);
    n_vec++;
    if (cap_data.size() != 3) begin
      n_err++; $display("FAIL rd_len: got %0d want 3", cap_data.size());
    end else if (cap_data[0] !== 8'h3A || cap_data[1] !== 8'h32 || cap_data[2] !== 8'h72 ||
                 cap_last[0] !== 1'b0 || cap_last[1] !== 1'b0 || cap_last[2] !== 1'b1) begin
      n_err++;
      $display("FAIL rd_frame: got %h %h %h last %b%b%b want 3a 32 72 last 001",
               cap_data[0], cap_data[1], cap_data[2], cap_last[0], cap_last[1], cap_last[2]);
    end
    n_vec++; if (rx_tready !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL rd_wait: got rx_tready %b busy %b want 1 1", rx_tready, busy);
    end
    send_rx_byte(8'hAB, 1'b0);
    send_rx_byte(8'hCD, 1'b0);
    send_rx_byte(8'h12, 1'b0);
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_early_rsp: got %b want 0", rsp_valid); end
    send_rx_byte(8'h34, 1'b1);
    n_vec++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'hABCD1234) begin
      n_err++; $display("FAIL rd_rsp: got valid %b err %b data %h want 1 0 abcd1234",
                        rsp_valid, rsp_error, rsp_rdata);
    end
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hABCD1234) begin
      n_err++; $display("FAIL rd_hold: got valid %b data %h want 0 abcd1234", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[7];
    exp = '{8'h3A, 8'h31, 8'h77, 8'h00, 8'h00, 8'h00, 8'h55};
    send_cmd(1'b1, 2'd1, 32'h00000055);
    capture_tx(1'b1);
    n_vec++; if (cap_data.size() != 7) begin n_err++; $display("FAIL bp_len: got %0d want 7", cap_data.size()); end
    for (int i = 0; i < 7 && i < cap_data.size(); i++) begin
      n_vec++;
      if (cap_data[i] !== exp[i] || cap_last[i] !== (i == 6)) begin
        n_err++;
        $display("FAIL bp_byte%0d: got %h last %b want %h last %b", i, cap_data[i], cap_last[i], exp[i], (i == 6));
      end
    end
    n_vec++; if (cap_hold_err != 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable stalls want 0", cap_hold_err); end
    n_vec++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0) begin
      n_err++; $display("FAIL bp_rsp: got valid %b err %b want 1 0", rsp_valid, rsp_error);
    end
    @(negedge clk);
  endtask

  task automatic test_rx_errors();
    send_cmd(1'b0, 2'd0, 32'h0);
    capture_tx(1'b0);
    n_vec++; if (cap_data.size() != 3 || cap_data[1] !== 8'h30) begin
      n_err++; $display("FAIL short_frame: got len %0d want 3 with reg byte 30", cap_data.size());
    end
    send_rx_byte(8'h11, 1'b0);
    send_rx_byte(8'h22, 1'b1);
    n_vec++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'hABCD1234) begin
      n_err++; $display("FAIL short_rsp: got valid %b err %b data %h want 1 1 abcd1234",
                        rsp_valid, rsp_error, rsp_rdata);
    end
    @(negedge clk);
    send_cmd(1'b0, 2'd0, 32'h0);
    capture_tx(1'b0);
    send_rx_byte(8'h01, 1'b0);
    send_rx_byte(8'h02, 1'b0);
    send_rx_byte(8'h03, 1'b0);
    send_rx_byte(8'h04, 1'b0);
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || rx_tready !== 1'b1) begin
      n_err++; $display("FAIL long_drain: got valid %b busy %b rx_tready %b want 0 1 1",
                        rsp_valid, busy, rx_tready);
    end
    send_rx_byte(8'h05, 1'b1);
    n_vec++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'hABCD1234) begin
      n_err++; $display("FAIL long_rsp: got valid %b err %b data %h want 1 1 abcd1234",
                        rsp_valid, rsp_error, rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int j;
    send_cmd(1'b0, 2'd3, 32'h0);
    capture_tx(1'b0);
    n_vec++; if (cap_data.size() != 3 || cap_data[1] !== 8'h33) begin
      n_err++; $display("FAIL tmo_frame: got len %0d want 3 with reg byte 33", cap_data.size());
    end
    j = 0;
    while (rsp_valid !== 1'b1 && j < 100) begin
      @(negedge clk); j++;
    end
    n_vec++; if (j != TIMEOUT_CYCLES) begin n_err++; $display("FAIL tmo_latency: got %0d cycles want %0d", j, TIMEOUT_CYCLES); end
    n_vec++; if (rsp_error !== 1'b1) begin n_err++; $display("FAIL tmo_error: got %b want 1", rsp_error); end
    @(negedge clk);
    n_vec++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL tmo_next: got ready %b busy %b valid %b want 1 0 0", cmd_ready, busy, rsp_valid);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp[7];
    exp = '{8'h3A, 8'h31, 8'h77, 8'h0F, 8'h1E, 8'h2D, 8'h3C};
    tx_tready = 1'b1;
    send_cmd(1'b1, 2'd3, 32'hDEADBEEF);
    repeat (5) @(negedge clk);
    n_vec++; if (tx_tvalid !== 1'b1 || tx_tdata !== 8'hBE) begin
      n_err++; $display("FAIL mid_pre: got valid %b data %h want 1 be", tx_tvalid, tx_tdata);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++; if (tx_tvalid !== 1'b0 || tx_tdata !== 8'h00 || tx_tlast !== 1'b0 || rx_tready !== 1'b1) begin
      n_err++; $display("FAIL mid_rst_tx: got valid %b data %h last %b rx_tready %b want 0 00 0 1",
                        tx_tvalid, tx_tdata, tx_tlast, rx_tready);
    end
    n_vec++; if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0 ||
                 busy !== 1'b0 || cmd_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_rsp: got valid %b err %b data %h busy %b ready %b want 0 0 0 0 0",
                        rsp_valid, rsp_error, rsp_rdata, busy, cmd_ready);
    end
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_after: got valid %b ready %b want 0 1", rsp_valid, cmd_ready);
    end
    send_cmd(1'b1, 2'd1, 32'h0F1E2D3C);
    capture_tx(1'b0);
    n_vec++; if (cap_data.size() != 7) begin n_err++; $display("FAIL mid_len: got %0d want 7", cap_data.size()); end
    for (int i = 0; i < 7 && i < cap_data.size(); i++) begin
      n_vec++;
      if (cap_data[i] !== exp[i] || cap_last[i] !== (i == 6)) begin
        n_err++;
        $display("FAIL mid_byte%0d: got %h last %b want %h last %b", i, cap_data[i], cap_last[i], exp[i], (i == 6));
      end
    end
    n_vec++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0) begin
      n_err++; $display("FAIL mid_rsp: got valid %b err %b want 1 0", rsp_valid, rsp_error);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_reg = 2'd0; cmd_wdata = 32'h0;
    tx_tready = 1'b1; rx_tvalid = 1'b0; rx_tdata = 8'h00; rx_tlast = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_rx_errors();
    test_timeout();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
